// File: rtl/blit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : blit_pkg
//  Purpose  : Shared types and default constants for the sprite blit engine:
//             FSM state encoding, the latched command record and a small
//             signed range helper used for screen clipping.
//  Ports    : (package - none)
//  Revision : 1.0  initial release
// ============================================================================
package blit_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_SRC_AW    = 18;
  localparam int DEF_COORD_W   = 10;
  localparam int DEF_SCREEN_W  = 640;
  localparam int DEF_SCREEN_H  = 480;
  localparam int DEF_PAL_IDX_W = 4;
  localparam logic [DEF_DATA_W-1:0] DEF_TRANSPARENT_KEY = 16'hF81F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

  // Command captured on the edge that accepts execute; the job only ever
  // looks at this copy, so software may change cmd_* while a job runs.
  typedef struct packed {
    logic [DEF_SRC_AW-1:0]  src_base;
    logic [DEF_COORD_W-1:0] width;
    logic [DEF_COORD_W-1:0] height;
    logic [DEF_COORD_W:0]   dst_x;
    logic [DEF_COORD_W:0]   dst_y;
    logic                   flip_x;
    logic                   transparent_en;
    logic                   indexed;
  } blit_cmd_t;

  // True when a signed coordinate lies inside 0 .. limit-1.
  function automatic logic in_range(input int v, input int limit);
    return (v >= 0) && (v < limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/blit_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : blit_addr_gen
//  Purpose  : Pipeline stage S0 of the blit engine. Walks the sprite in
//             raster order, producing the registered sprite ROM address
//             (with optional horizontal mirror) and the signed destination
//             coordinate of the pixel currently presented to the ROM.
//  Ports    : clk, reset          clock / synchronous active-high reset
//             start               load pixel (0,0) from start_* inputs
//             advance             pipeline not stalled; step to next pixel
//             start_base/width/flip  raw command values used on start
//             base/width/height/flip/dst_x/dst_y  latched command
//             src_addr            ROM address of the S0 pixel
//             pix_valid/pix_last  S0 holds a pixel / it is the final one
//             dst_x, dst_y        signed destination of the S0 pixel
//  Revision : 1.0  initial release
// ============================================================================
module blit_addr_gen #(
  parameter int SRC_AW  = 18,
  parameter int COORD_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 advance,
  input  logic [SRC_AW-1:0]    start_base,
  input  logic [COORD_W-1:0]   start_width,
  input  logic                 start_flip,
  input  logic [SRC_AW-1:0]    base,
  input  logic [COORD_W-1:0]   width,
  input  logic [COORD_W-1:0]   height,
  input  logic                 flip,
  input  logic [COORD_W:0]     dst_x0,
  input  logic [COORD_W:0]     dst_y0,
  output logic [SRC_AW-1:0]    src_addr,
  output logic                 pix_valid,
  output logic                 pix_last,
  output logic [COORD_W+1:0]   dst_x,
  output logic [COORD_W+1:0]   dst_y
);

  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [SRC_AW-1:0]  row_off_q, row_off_d;   // row * width, built incrementally
  logic [SRC_AW-1:0]  src_addr_q, src_addr_d;
  logic               valid_q, valid_d;

  logic [COORD_W-1:0] w_m1;
  logic [COORD_W-1:0] h_m1;
  logic [COORD_W-1:0] start_col;
  logic [COORD_W-1:0] next_src_col;
  logic               last_col;
  logic               last_row;

  assign w_m1      = width - COORD_W'(1);
  assign h_m1      = height - COORD_W'(1);
  assign last_col  = (col_q == w_m1);
  assign last_row  = (row_q == h_m1);
  assign start_col = start_flip ? (start_width - COORD_W'(1)) : '0;

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    row_off_d    = row_off_q;
    src_addr_d   = src_addr_q;
    valid_d      = valid_q;
    next_src_col = '0;
    if (start) begin
      // Address of pixel (0,0) comes straight from the raw command so the
      // ROM sees it on the cycle after execute is accepted.
      col_d      = '0;
      row_d      = '0;
      row_off_d  = '0;
      valid_d    = 1'b1;
      src_addr_d = start_base + {{(SRC_AW-COORD_W){1'b0}}, start_col};
    end else if (valid_q && advance) begin
      if (last_col && last_row) begin
        valid_d = 1'b0;
      end else begin
        if (last_col) begin
          col_d     = '0;
          row_d     = row_q + COORD_W'(1);
          row_off_d = row_off_q + {{(SRC_AW-COORD_W){1'b0}}, width};
        end else begin
          col_d = col_q + COORD_W'(1);
        end
        next_src_col = flip ? (w_m1 - col_d) : col_d;
        src_addr_d   = base + row_off_d + {{(SRC_AW-COORD_W){1'b0}}, next_src_col};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      row_off_q  <= '0;
      src_addr_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      row_off_q  <= row_off_d;
      src_addr_q <= src_addr_d;
      valid_q    <= valid_d;
    end
  end

  assign src_addr  = src_addr_q;
  assign pix_valid = valid_q;
  assign pix_last  = last_col && last_row;

  // Two extra bits: sign plus headroom so dst + col never wraps on-screen.
  assign dst_x = {dst_x0[COORD_W], dst_x0} + {2'b00, col_q};
  assign dst_y = {dst_y0[COORD_W], dst_y0} + {2'b00, row_q};

endmodule

`default_nettype wire

// File: rtl/blit_engine.sv
`default_nettype none
// ============================================================================
//  Module   : blit_engine
//  Purpose  : Sprite copy engine. Copies a WxH rectangle from the sprite ROM
//             to the frame writer with horizontal flip, colour-key
//             transparency, screen clipping, 4-bit palette mode and writer
//             backpressure. Three-stage pipeline:
//               S0 address generator -> src_addr
//               S1 src_data -> colour / keep decision
//               S2 program_* output registers
//  Ports    : clk, reset                 clock / sync active-high reset
//             execute, done, busy        software 4-phase handshake
//             cmd_*                      job description (latched at start)
//             src_addr, src_data         sprite ROM (1-cycle read latency)
//             palette_index/_color       external combinational palette
//             program_x/y/data/write     frame writer request
//             program_ready              writer accept; low stalls pipeline
//  Revision : 1.0  initial release
// ============================================================================
module blit_engine
  import blit_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SRC_AW    = DEF_SRC_AW,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int PAL_IDX_W = DEF_PAL_IDX_W,
  parameter logic [DATA_W-1:0] TRANSPARENT_KEY = DEF_TRANSPARENT_KEY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 execute,
  output logic                 done,
  output logic                 busy,
  input  logic [SRC_AW-1:0]    cmd_src_base,
  input  logic [COORD_W-1:0]   cmd_width,
  input  logic [COORD_W-1:0]   cmd_height,
  input  logic [COORD_W:0]     cmd_dst_x,
  input  logic [COORD_W:0]     cmd_dst_y,
  input  logic                 cmd_flip_x,
  input  logic                 cmd_transparent_en,
  input  logic                 cmd_indexed,
  output logic [SRC_AW-1:0]    src_addr,
  input  logic [DATA_W-1:0]    src_data,
  output logic [PAL_IDX_W-1:0] palette_index,
  input  logic [DATA_W-1:0]    palette_color,
  output logic [COORD_W-1:0]   program_x,
  output logic [COORD_W-1:0]   program_y,
  output logic [DATA_W-1:0]    program_data,
  output logic                 program_write,
  input  logic                 program_ready
);

  // The command record is sized by the package; the width parameters are
  // expected to stay at their package defaults.
  blit_state_t state_q, state_d;
  blit_cmd_t   cmd_q, cmd_d, cmd_raw;
  logic        start;
  logic        stall;

  // S0 outputs
  logic               pix_valid;
  logic               pix_last;
  logic [COORD_W+1:0] dst_x;
  logic [COORD_W+1:0] dst_y;
  logic               on_screen;

  // S1 registers
  logic               s1_valid_q, s1_valid_d;
  logic               s1_on_q, s1_on_d;
  logic [COORD_W-1:0] s1_x_q, s1_x_d;
  logic [COORD_W-1:0] s1_y_q, s1_y_d;

  // src_data capture used while stalled (see below)
  logic               stall_q;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic [DATA_W-1:0]  src_eff;
  logic [DATA_W-1:0]  colour;
  logic               keep;

  // S2 registers
  logic               pw_q, pw_d;
  logic [COORD_W-1:0] px_q, px_d;
  logic [COORD_W-1:0] py_q, py_d;
  logic [DATA_W-1:0]  pd_q, pd_d;

  always_comb begin
    cmd_raw                = '0;
    cmd_raw.src_base       = cmd_src_base;
    cmd_raw.width          = cmd_width;
    cmd_raw.height         = cmd_height;
    cmd_raw.dst_x          = cmd_dst_x;
    cmd_raw.dst_y          = cmd_dst_y;
    cmd_raw.flip_x         = cmd_flip_x;
    cmd_raw.transparent_en = cmd_transparent_en;
    cmd_raw.indexed        = cmd_indexed;
  end

  // A pending write the writer refuses freezes every stage.
  assign stall = pw_q && !program_ready;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (execute) begin
          cmd_d = cmd_raw;
          if ((cmd_width == '0) || (cmd_height == '0)) begin
            state_d = DONE;
          end else begin
            start   = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (pix_valid && pix_last && !stall) state_d = DRAIN;
      end
      DRAIN: begin
        // S0/S1 empty and S2 either empty or transferring this edge.
        if (!pix_valid && !s1_valid_q && !stall) state_d = DONE;
      end
      DONE: begin
        if (!execute) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- S0
  blit_addr_gen #(
    .SRC_AW  (SRC_AW),
    .COORD_W (COORD_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .advance     (!stall),
    .start_base  (cmd_src_base),
    .start_width (cmd_width),
    .start_flip  (cmd_flip_x),
    .base        (cmd_q.src_base),
    .width       (cmd_q.width),
    .height      (cmd_q.height),
    .flip        (cmd_q.flip_x),
    .dst_x0      (cmd_q.dst_x),
    .dst_y0      (cmd_q.dst_y),
    .src_addr    (src_addr),
    .pix_valid   (pix_valid),
    .pix_last    (pix_last),
    .dst_x       (dst_x),
    .dst_y       (dst_y)
  );

  assign on_screen = in_range(int'($signed(dst_x)), SCREEN_W) &&
                     in_range(int'($signed(dst_y)), SCREEN_H);

  // ---------------------------------------------------------------- S1
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_on_d    = s1_on_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    if (!stall) begin
      s1_valid_d = pix_valid;
      s1_on_d    = on_screen;
      s1_x_d     = dst_x[COORD_W-1:0];
      s1_y_d     = dst_y[COORD_W-1:0];
    end
  end

  // The ROM re-reads src_addr every edge, so after the first stalled cycle
  // src_data already belongs to the next pixel. The S1 pixel's word is
  // therefore captured and replayed until the stall clears.
  assign src_eff       = stall_q ? hold_q : src_data;
  assign hold_d        = src_eff;
  assign palette_index = src_eff[PAL_IDX_W-1:0];
  assign colour        = cmd_q.indexed ? palette_color : src_eff;
  assign keep          = s1_valid_q && s1_on_q &&
                         !(cmd_q.transparent_en && (colour == TRANSPARENT_KEY));

  // ---------------------------------------------------------------- S2
  always_comb begin
    pw_d = pw_q;
    px_d = px_q;
    py_d = py_q;
    pd_d = pd_q;
    if (!stall) begin
      pw_d = keep;
      if (keep) begin
        px_d = s1_x_q;
        py_d = s1_y_q;
        pd_d = colour;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_on_q    <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      stall_q    <= 1'b0;
      hold_q     <= '0;
      pw_q       <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      pd_q       <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      s1_valid_q <= s1_valid_d;
      s1_on_q    <= s1_on_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      stall_q    <= stall;
      hold_q     <= hold_d;
      pw_q       <= pw_d;
      px_q       <= px_d;
      py_q       <= py_d;
      pd_q       <= pd_d;
    end
  end

  assign done          = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign program_write = pw_q;
  assign program_x     = px_q;
  assign program_y     = py_q;
  assign program_data  = pd_q;

endmodule

`default_nettype wire

// File: tb/tb_blit_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blit_engine
//  Purpose  : Directed self-checking bench for blit_engine. A reference
//             model pushes the expected writes of each job to a queue; every
//             accepted write is popped and compared.
//  Revision : 1.0  initial release
// ============================================================================
module tb_blit_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        execute;
  logic        done;
  logic        busy;
  logic [17:0] cmd_src_base;
  logic [9:0]  cmd_width;
  logic [9:0]  cmd_height;
  logic [10:0] cmd_dst_x;
  logic [10:0] cmd_dst_y;
  logic        cmd_flip_x;
  logic        cmd_transparent_en;
  logic        cmd_indexed;
  logic [17:0] src_addr;
  logic [15:0] src_data;
  logic [3:0]  palette_index;
  logic [15:0] palette_color;
  logic [9:0]  program_x;
  logic [9:0]  program_y;
  logic [15:0] program_data;
  logic        program_write;
  logic        program_ready;

  int total = 0;
  int bad   = 0;
  bit key_en = 1'b0;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] d;
  } wr_t;
  wr_t exp_q[$];

  blit_engine dut (
    .clk                (clk),
    .reset              (reset),
    .execute            (execute),
    .done               (done),
    .busy               (busy),
    .cmd_src_base       (cmd_src_base),
    .cmd_width          (cmd_width),
    .cmd_height         (cmd_height),
    .cmd_dst_x          (cmd_dst_x),
    .cmd_dst_y          (cmd_dst_y),
    .cmd_flip_x         (cmd_flip_x),
    .cmd_transparent_en (cmd_transparent_en),
    .cmd_indexed        (cmd_indexed),
    .src_addr           (src_addr),
    .src_data           (src_data),
    .palette_index      (palette_index),
    .palette_color      (palette_color),
    .program_x          (program_x),
    .program_y          (program_y),
    .program_data       (program_data),
    .program_write      (program_write),
    .program_ready      (program_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_val(input logic [17:0] a);
    if (key_en && (a == 18'h00101)) return 16'hF81F;
    return a[15:0];
  endfunction

  function automatic logic [15:0] pal_val(input logic [3:0] i);
    if (i == 4'd3) return 16'h07E0;
    return {4'hA, 8'h00, i};
  endfunction

  // Synchronous sprite ROM, one cycle read latency.
  always @(posedge clk) src_data <= rom_val(src_addr);
  always_comb palette_color = pal_val(palette_index);

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, what, obs, exp);
    end
  endtask

  task automatic push_model(input logic [17:0] base, input int w, input int h,
                            input int dx, input int dy,
                            input bit fl, input bit te, input bit ix);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int          sc;
        int          x;
        int          y;
        logic [17:0] a;
        logic [15:0] d;
        logic [15:0] col;
        sc  = fl ? (w - 1 - c) : c;
        a   = base + 18'(r * w + sc);
        d   = rom_val(a);
        col = ix ? pal_val(d[3:0]) : d;
        x   = dx + c;
        y   = dy + r;
        if (x >= 0 && x < 640 && y >= 0 && y < 480 && !(te && col == 16'hF81F))
          exp_q.push_back({10'(x), 10'(y), col});
      end
    end
  endtask

  task automatic run_job(input string tag, input logic [17:0] base,
                         input int w, input int h, input int dx, input int dy,
                         input bit fl, input bit te, input bit ix,
                         input int exp_count, input bit chk_lat,
                         input int stall_at, input int stall_len,
                         input int reset_after);
    int          writes = 0;
    int          first_it = -1;
    int          last_it = -1;
    int          done_it = -1;
    bit          prev_stall = 1'b0;
    bit          hit_reset = 1'b0;
    logic [9:0]  hx = '0;
    logic [9:0]  hy = '0;
    logic [15:0] hd = '0;
    wr_t         e;

    exp_q.delete();
    push_model(base, w, h, dx, dy, fl, te, ix);

    cmd_src_base       = base;
    cmd_width          = 10'(w);
    cmd_height         = 10'(h);
    cmd_dst_x          = 11'(dx);
    cmd_dst_y          = 11'(dy);
    cmd_flip_x         = fl;
    cmd_transparent_en = te;
    cmd_indexed        = ix;
    program_ready      = 1'b1;
    execute            = 1'b1;

    for (int it = 1; it <= 300; it++) begin
      @(negedge clk);
      if (it == 1) check(tag, "busy_run", 32'(busy), 32'd1);
      if (prev_stall) begin
        check(tag, "hold_write", 32'(program_write), 32'd1);
        check(tag, "hold_x", 32'(program_x), 32'(hx));
        check(tag, "hold_y", 32'(program_y), 32'(hy));
        check(tag, "hold_data", 32'(program_data), 32'(hd));
      end
      if (done) begin
        done_it = it;
        break;
      end
      program_ready = !(it >= stall_at && it < stall_at + stall_len);
      prev_stall    = program_write && !program_ready;
      hx = program_x;
      hy = program_y;
      hd = program_data;
      if (program_write && first_it < 0) first_it = it;
      if (program_write && program_ready) begin
        writes++;
        last_it = it;
        if (exp_q.size() == 0) begin
          check(tag, "extra_write", 32'(writes), 32'(exp_count));
        end else begin
          e = exp_q.pop_front();
          check(tag, "x", 32'(program_x), 32'(e.x));
          check(tag, "y", 32'(program_y), 32'(e.y));
          check(tag, "data", 32'(program_data), 32'(e.d));
        end
        if (reset_after > 0 && writes == reset_after) begin
          reset     = 1'b1;
          hit_reset = 1'b1;
          break;
        end
      end
      // Command inputs change after acceptance; the job must not notice.
      if (it == 1) begin
        cmd_src_base = 18'h3_0000;
        cmd_dst_x    = 11'd0;
        cmd_dst_y    = 11'd0;
        cmd_flip_x   = ~fl;
        cmd_indexed  = ~ix;
      end
    end

    if (hit_reset) begin
      @(negedge clk);
      check(tag, "rst_write", 32'(program_write), 32'd0);
      check(tag, "rst_busy", 32'(busy), 32'd0);
      check(tag, "rst_done", 32'(done), 32'd0);
      check(tag, "rst_src_addr", 32'(src_addr), 32'd0);
      reset         = 1'b0;
      execute       = 1'b0;
      program_ready = 1'b1;
      exp_q.delete();
      repeat (4) begin
        @(negedge clk);
        check(tag, "post_rst_write", 32'(program_write), 32'd0);
      end
      check(tag, "post_rst_busy", 32'(busy), 32'd0);
      return;
    end

    check(tag, "done_seen", 32'(done_it > 0), 32'd1);
    if (chk_lat) begin
      check(tag, "first_write_lat", 32'(first_it), 32'd3);
      check(tag, "done_lat", 32'(done_it - last_it), 32'd1);
    end
    check(tag, "write_count", 32'(writes), 32'(exp_count));
    check(tag, "queue_empty", 32'(exp_q.size()), 32'd0);
    program_ready = 1'b1;
    // execute held high: stays in DONE, never restarts
    repeat (3) begin
      @(negedge clk);
      check(tag, "done_hold", 32'(done), 32'd1);
      check(tag, "no_restart", 32'(program_write), 32'd0);
    end
    execute = 1'b0;
    @(negedge clk);
    check(tag, "done_fall", 32'(done), 32'd0);
    check(tag, "busy_fall", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset              = 1'b1;
    execute            = 1'b0;
    program_ready      = 1'b1;
    cmd_src_base       = '0;
    cmd_width          = '0;
    cmd_height         = '0;
    cmd_dst_x          = '0;
    cmd_dst_y          = '0;
    cmd_flip_x         = 1'b0;
    cmd_transparent_en = 1'b0;
    cmd_indexed        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", "done", 32'(done), 32'd0);
    check("reset", "busy", 32'(busy), 32'd0);
    check("reset", "write", 32'(program_write), 32'd0);
    check("reset", "src_addr", 32'(src_addr), 32'd0);
    check("reset", "x", 32'(program_x), 32'd0);
    check("reset", "y", 32'(program_y), 32'd0);
    check("reset", "data", 32'(program_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    //       tag        base      w  h  dx  dy   fl te ix  n lat stall      rst
    run_job("plain",   18'h100, 4, 2, 10, 20,  0, 0, 0, 8, 1, 0, 0, 0);
    run_job("flip",    18'h100, 4, 2, 10, 20,  1, 0, 0, 8, 1, 0, 0, 0);
    key_en = 1'b1;
    run_job("key_on",  18'h100, 4, 2, 10, 20,  0, 1, 0, 7, 1, 0, 0, 0);
    run_job("key_off", 18'h100, 4, 2, 10, 20,  0, 0, 0, 8, 1, 0, 0, 0);
    key_en = 1'b0;
    run_job("clip",    18'h100, 4, 4, -2, 478, 0, 0, 0, 4, 0, 0, 0, 0);
    run_job("stall",   18'h100, 4, 2, 10, 20,  0, 0, 0, 8, 1, 5, 5, 0);
    run_job("index",   18'h100, 4, 2, 10, 20,  0, 0, 1, 8, 1, 0, 0, 0);
    run_job("reset",   18'h100, 4, 2, 10, 20,  0, 0, 0, 8, 0, 0, 0, 3);
    run_job("zero_w",  18'h100, 0, 2, 10, 20,  0, 0, 0, 0, 0, 0, 0, 0);
    run_job("again",   18'h200, 3, 3, 637, 0,  1, 0, 0, 9, 1, 4, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
